blinker_sysid_checker: RTL

Avalon-MM read master sitting directly downstream of the system-ID slave in the blinker system. After reset (and on request) it reads the ID word (address 0) and timestamp word (address 1), compares both against build-time expected values, and reports pass/fail on status outputs and a diagnostic LED. A timeout guards against a hung fabric.

---
 rtl/blinker_sysid_pkg.sv | 18 +
 rtl/blinker_sysid_if.sv | 10 +
 rtl/blinker_sysid_blink.sv | 39 +++
 rtl/blinker_sysid_checker.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/blinker_sysid_pkg.sv
// Shared types and constants for the blinker system-ID checker.
package blinker_sysid_pkg;

  typedef enum logic [2:0] {
    ST_ARM,
    ST_RD_ID,
    ST_RD_TS,
    ST_DONE,
    ST_IDLE
  } state_e;

  localparam logic [31:0] SYSID_ID_DEFAULT = 32'd4919;
  localparam logic [31:0] SYSID_TS_DEFAULT = 32'd1462918572;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/blinker_sysid_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid slave.
interface blinker_sysid_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (output avm_address, avm_read, input avm_waitrequest, avm_readdata);
  modport slave  (input avm_address, avm_read, output avm_waitrequest, avm_readdata);
endinterface

// File: rtl/blinker_sysid_blink.sv
// Diagnostic LED driver: off when disabled, solid or blinking at HALF cycles per phase.
module blinker_sysid_blink #(
  parameter int unsigned HALF = 12500000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable_i,
  input  logic mode_i,     // 1 = blink, 0 = solid
  input  logic restart_i,
  output logic led_o
);

  localparam logic [31:0] LAST = 32'(HALF - 1);

  logic [31:0] cnt_q;
  logic        led_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      led_q <= 1'b0;
    end else if (!enable_i) begin
      cnt_q <= '0;
      led_q <= 1'b0;
    end else if (restart_i || !mode_i) begin
      // A fresh result always starts in the lit phase.
      cnt_q <= '0;
      led_q <= 1'b1;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
      led_q <= ~led_q;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/blinker_sysid_checker.sv
// Reads sysid ID/timestamp after reset and on start, reports match status and drives an LED.
// Optional periodic re-check: define BLINKER_SYSID_RECHECK_EN.
module blinker_sysid_checker
  import blinker_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_ID_DEFAULT,
  parameter logic [31:0] EXPECTED_TS    = SYSID_TS_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RECHECK_CYCLES = 50000000,
  parameter int unsigned BLINK_HALF     = 12500000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start_i,
  blinker_sysid_if.master       avm,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic                  id_ok_o,
  output logic                  ts_ok_o,
  output logic                  timeout_o,
  output logic                  led_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 || RECHECK_CYCLES < 1) begin : g_bad_param
    $error("blinker_sysid_checker: TIMEOUT_CYCLES or RECHECK_CYCLES out of range");
  end

  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [15:0] stall_q;
  logic        id_match_q, ts_match_q;
  logic        read_q, addr_q, busy_q;
  logic        valid_q, id_ok_q, ts_ok_q, timeout_q;
  logic        valid_d, id_ok_d, ts_ok_d, timeout_d;
  logic        in_rd, stall_exp, go, result_chg;

  assign in_rd     = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);
  assign stall_exp = in_rd && avm.avm_waitrequest && (stall_q == STALL_LAST);

`ifdef BLINKER_SYSID_RECHECK_EN
  localparam logic [31:0] RC_LAST = 32'(RECHECK_CYCLES - 1);
  logic [31:0] rc_q;

  // Held at zero outside IDLE, so it restarts on every IDLE entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                rc_q <= '0;
    else if (state_q != ST_IDLE) rc_q <= '0;
    else                         rc_q <= rc_q + 32'd1;
  end

  assign go = (state_q == ST_IDLE) && (start_i || (rc_q == RC_LAST));
`else
  assign go = (state_q == ST_IDLE) && start_i;
`endif

  // Next result, shared with the LED driver so it reacts in the same cycle.
  always_comb begin
    valid_d   = valid_q;
    id_ok_d   = id_ok_q;
    ts_ok_d   = ts_ok_q;
    timeout_d = timeout_q;
    if (state_q == ST_DONE) begin
      valid_d   = 1'b1;
      id_ok_d   = id_match_q;
      ts_ok_d   = ts_match_q;
      timeout_d = 1'b0;
    end else if (stall_exp) begin
      valid_d   = 1'b1;
      id_ok_d   = 1'b0;
      ts_ok_d   = 1'b0;
      timeout_d = 1'b1;
    end
  end

  assign result_chg = {valid_d, id_ok_d, ts_ok_d, timeout_d} !=
                      {valid_q, id_ok_q, ts_ok_q, timeout_q};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_ARM;
      stall_q    <= '0;
      id_match_q <= 1'b0;
      ts_match_q <= 1'b0;
      read_q     <= 1'b0;
      addr_q     <= SYSID_ADDR_ID;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      id_ok_q   <= id_ok_d;
      ts_ok_q   <= ts_ok_d;
      timeout_q <= timeout_d;
      case (state_q)
        ST_ARM: begin
          state_q <= ST_RD_ID;
          read_q  <= 1'b1;
          busy_q  <= 1'b1;
          addr_q  <= SYSID_ADDR_ID;
          stall_q <= '0;
        end
        ST_RD_ID, ST_RD_TS: begin
          if (stall_exp) begin
            state_q <= ST_IDLE;
            read_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (avm.avm_waitrequest) begin
            stall_q <= stall_q + 16'd1;
          end else if (state_q == ST_RD_ID) begin
            id_match_q <= (avm.avm_readdata == EXPECTED_ID);
            state_q    <= ST_RD_TS;
            addr_q     <= SYSID_ADDR_TS;
            stall_q    <= '0;
          end else begin
            ts_match_q <= (avm.avm_readdata == EXPECTED_TS);
            state_q    <= ST_DONE;
            read_q     <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        ST_IDLE: begin
          if (go) begin
            state_q <= ST_RD_ID;
            read_q  <= 1'b1;
            busy_q  <= 1'b1;
            addr_q  <= SYSID_ADDR_ID;
            stall_q <= '0;
          end
        end
        default: state_q <= ST_ARM;
      endcase
    end
  end

  blinker_sysid_blink #(.HALF(BLINK_HALF)) u_blink (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable_i  (valid_d),
    .mode_i    (id_ok_d & ts_ok_d),
    .restart_i (result_chg),
    .led_o     (led_o)
  );

  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;
  assign busy_o          = busy_q;
  assign valid_o         = valid_q;
  assign id_ok_o         = id_ok_q;
  assign ts_ok_o         = ts_ok_q;
  assign timeout_o       = timeout_q;

endmodule
